writeback_cycle: RTL and testbench
==================================

WRITEBACK_CYCLE -- requirements
Module: writeback_cycle

Interface
REQ-001 Parameter: CNT_WIDTH, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 stall  input  1  hold the MEM/WB register contents.
REQ-005 flush  input  1  invalidate the instruction entering the MEM/WB register.
REQ-006 valid_M  input  1  memory-stage slot holds a real instruction.
REQ-007 RegWrite_M  input  1  instruction writes a register.
REQ-008 MemToReg_M  input  1  result comes from memory (1) or ALU (0).
REQ-009 LoadType_M  input  3  000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned.
REQ-010 WriteRegister_M  input  5  destination register number.
REQ-011 ALUResult_M  input  32  ALU result / load address.
REQ-012 ReadData_M  input  32  raw memory word.
REQ-013 RegWrite_W  output  1  write enable to the register file.
REQ-014 WriteRegister_W  output  5  register-file write address.
REQ-015 WriteData_W  output  32  register-file write data.
REQ-016 valid_W  output  1  writeback slot holds a real instruction.
REQ-017 misalign_W  output  1  current writeback load is misaligned.
REQ-018 retired_count  output  CNT_WIDTH  count of retired valid instructions.

Function
REQ-019 The MEM/WB register SHALL capture all *_M inputs on each rising edge unless stall=1, giving 1-cycle latency from M to W.
REQ-020 With stall=1, the MEM/WB register SHALL hold its contents and the outputs SHALL be unchanged.
REQ-021 With flush=1 and stall=0, valid_W SHALL become 0 on the next edge; the other captured fields are don't-care.
REQ-022 With flush=1 and stall=1 together, flush SHALL win: valid_W cleared, other fields held.
REQ-023 RegWrite_W SHALL equal valid_W AND registered RegWrite AND (WriteRegister_W != 0); writes to $0 are never issued.
REQ-024 WriteData_W SHALL be the registered ALUResult when registered MemToReg=0, otherwise the extracted load value.
REQ-025 Byte extraction SHALL be big-endian: ALUResult[1:0]=0 selects ReadData[31:24], 1 selects [23:16], 2 selects [15:8], 3 selects [7:0].
REQ-026 Halfword extraction SHALL use ALUResult[1]: 0 selects [31:16], 1 selects [15:0].
REQ-027 Signed types SHALL sign-extend to 32 bits; unsigned types SHALL zero-extend.
REQ-028 LoadType codes 101-111 SHALL be treated as word.
REQ-029 misalign_W SHALL be 1 when valid_W AND MemToReg, and either a halfword load has ALUResult[0]=1 or a word load has ALUResult[1:0]!=0. The write still proceeds using the REQ-025/026 selection.
REQ-030 The extraction and select logic SHALL be combinational from the MEM/WB register; there is no additional latency.
REQ-031 retired_count SHALL increment by 1 on each edge where valid_W=1 and stall=0, wrapping modulo 2^CNT_WIDTH.

Reset
REQ-032 On a rising edge with rst=0:
- valid_W, RegWrite_W and misalign_W SHALL be 0.
- WriteRegister_W and WriteData_W SHALL be 0.
- retired_count SHALL be 0.
REQ-033 Reset SHALL override stall and flush, and SHALL discard any in-flight instruction.

Structure
REQ-034 LoadType encodings SHALL reside in the shared package mips_pkg, alongside the existing control encodings.
REQ-035 Load extraction SHALL be a sub-module named load_extender (combinational; inputs: data, address low bits, type; output: 32-bit value).

Verification
REQ-036 ALU op: RegWrite=1, MemToReg=0, WriteRegister=5, ALUResult=0x0000_00AB, valid -> next cycle RegWrite_W=1, WriteRegister_W=5, WriteData_W=0x0000_00AB.
REQ-037 Byte loads from ReadData=0x8192_A3F4:
- LB, addr low 2 -> WriteData_W=0xFFFF_FFA3.
- LBU, addr low 2 -> 0x0000_00A3.
- LH, addr low 0 -> 0xFFFF_8192.
REQ-038 Write to $0 with RegWrite=1 -> RegWrite_W=0; retired_count still increments.
REQ-039 Stall and flush sequence:
- Stall for 3 cycles -> outputs held, count frozen.
- Then flush=1 with stall=1 -> valid_W=0 next cycle.
REQ-040 Word load with addr 0x1002 -> misalign_W=1 and WriteData_W = ReadData. Reset asserted mid-stream -> all outputs 0 next edge.
REQ-041 Preload retired_count to all-ones via a retire run, retire one more -> count wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared pipeline control encodings, load types and MEM/WB layout.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    // Codes 101-111 are not enumerated; they behave as a word load.
    typedef enum logic [2:0] {
        LT_WORD   = 3'b000,
        LT_BYTE_S = 3'b001,
        LT_BYTE_U = 3'b010,
        LT_HALF_S = 3'b011,
        LT_HALF_U = 3'b100
    } load_type_e;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic [2:0]  loadtype;
        logic [4:0]  wreg;
        logic [31:0] alu;
        logic [31:0] rdata;
    } mem_wb_t;

    function automatic logic lt_is_half(input logic [2:0] lt);
        return (lt == LT_HALF_S) || (lt == LT_HALF_U);
    endfunction

    function automatic logic lt_is_word(input logic [2:0] lt);
        return (lt == LT_WORD) || (lt > LT_HALF_U);
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/load_extender.sv
`default_nettype none
// ============================================================================
// Module   : load_extender
// Purpose  : Big-endian byte/halfword select with sign or zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module load_extender
    import mips_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_load_type,
    output logic [31:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = 8'h00;
        w_half  = 16'h0000;
        o_value = i_data;

        case (i_addr_lo)
            2'd0:    w_byte = i_data[31:24];
            2'd1:    w_byte = i_data[23:16];
            2'd2:    w_byte = i_data[15:8];
            default: w_byte = i_data[7:0];
        endcase

        w_half = i_addr_lo[1] ? i_data[15:0] : i_data[31:16];

        case (i_load_type)
            LT_BYTE_S: o_value = {{24{w_byte[7]}}, w_byte};
            LT_BYTE_U: o_value = {24'h000000, w_byte};
            LT_HALF_S: o_value = {{16{w_half[15]}}, w_half};
            LT_HALF_U: o_value = {16'h0000, w_half};
            default:   o_value = i_data;
        endcase
    end

endmodule : load_extender
`default_nettype wire

// File: rtl/writeback_cycle.sv
`default_nettype none
// ============================================================================
// Module   : writeback_cycle
// Purpose  : MEM/WB pipeline register, load extraction and retirement counter.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_cycle
    import mips_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_M,
    input  logic                 RegWrite_M,
    input  logic                 MemToReg_M,
    input  logic [2:0]           LoadType_M,
    input  logic [4:0]           WriteRegister_M,
    input  logic [31:0]          ALUResult_M,
    input  logic [31:0]          ReadData_M,
    output logic                 RegWrite_W,
    output logic [4:0]           WriteRegister_W,
    output logic [31:0]          WriteData_W,
    output logic                 valid_W,
    output logic                 misalign_W,
    output logic [CNT_WIDTH-1:0] retired_count
);

    mem_wb_t                r_mw;
    mem_wb_t                w_mw_next;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [31:0]            w_load_value;

    always_comb begin
        w_mw_next          = '0;
        w_mw_next.valid    = valid_M;
        w_mw_next.regwrite = RegWrite_M;
        w_mw_next.memtoreg = MemToReg_M;
        w_mw_next.loadtype = LoadType_M;
        w_mw_next.wreg     = WriteRegister_M;
        w_mw_next.alu      = ALUResult_M;
        w_mw_next.rdata    = ReadData_M;
    end

    // Flush only kills valid, so under stall+flush the other fields stay held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mw    <= '0;
            r_count <= '0;
        end else begin
            if (!stall) begin
                r_mw <= w_mw_next;
            end
            if (flush) begin
                r_mw.valid <= 1'b0;
            end
            if (r_mw.valid && !stall) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    load_extender u_load_extender (
        .i_data      (r_mw.rdata),
        .i_addr_lo   (r_mw.alu[1:0]),
        .i_load_type (r_mw.loadtype),
        .o_value     (w_load_value)
    );

    assign valid_W         = r_mw.valid;
    assign WriteRegister_W = r_mw.wreg;
    assign RegWrite_W      = r_mw.valid && r_mw.regwrite && (r_mw.wreg != 5'd0);
    assign WriteData_W     = r_mw.memtoreg ? w_load_value : r_mw.alu;
    assign misalign_W      = r_mw.valid && r_mw.memtoreg &&
                             ((lt_is_half(r_mw.loadtype) && r_mw.alu[0]) ||
                              (lt_is_word(r_mw.loadtype) && (r_mw.alu[1:0] != 2'b00)));
    assign retired_count   = r_count;

endmodule : writeback_cycle
`default_nettype wire

// File: tb/tb_writeback_cycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_cycle
// Purpose  : Directed and randomized checks of writeback_cycle against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_cycle;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, stall, flush, valid_M, RegWrite_M, MemToReg_M;
    logic [2:0]    LoadType_M;
    logic [4:0]    WriteRegister_M;
    logic [31:0]   ALUResult_M, ReadData_M;
    logic          RegWrite_W, valid_W, misalign_W;
    logic [4:0]    WriteRegister_W;
    logic [31:0]   WriteData_W;
    logic [CW-1:0] retired_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: the instruction last accepted into writeback.
    bit          m_valid, m_rw, m_m2r;
    int unsigned m_type, m_wreg, m_alu, m_rdata, m_count;

    writeback_cycle #(.CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .valid_M         (valid_M),
        .RegWrite_M      (RegWrite_M),
        .MemToReg_M      (MemToReg_M),
        .LoadType_M      (LoadType_M),
        .WriteRegister_M (WriteRegister_M),
        .ALUResult_M     (ALUResult_M),
        .ReadData_M      (ReadData_M),
        .RegWrite_W      (RegWrite_W),
        .WriteRegister_W (WriteRegister_W),
        .WriteData_W     (WriteData_W),
        .valid_W         (valid_W),
        .misalign_W      (misalign_W),
        .retired_count   (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int unsigned extract(input int unsigned rd, input int unsigned a,
                                            input int unsigned t);
        int b, h;
        b = int'((rd >> (8 * (3 - (a % 4)))) % 256);
        h = int'(((a / 2) % 2 == 1) ? (rd % 65536) : (rd / 65536));
        case (t)
            1: return int'(b >= 128 ? b - 256 : b);
            2: return b;
            3: return int'(h >= 32768 ? h - 65536 : h);
            4: return h;
            default: return rd;
        endcase
    endfunction

    function automatic bit exp_misalign();
        bit half, word;
        half = (m_type == 3) || (m_type == 4);
        word = (m_type == 0) || (m_type >= 5);
        return m_valid && m_m2r && ((half && (m_alu % 2 == 1)) || (word && (m_alu % 4 != 0)));
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_valid"},    32'(valid_W),         32'(m_valid));
        check({tag, "_regwr"},    32'(RegWrite_W),      32'(m_valid && m_rw && m_wreg != 0));
        check({tag, "_wreg"},     32'(WriteRegister_W), m_wreg);
        check({tag, "_wdata"},    WriteData_W,          m_m2r ? extract(m_rdata, m_alu, m_type) : m_alu);
        check({tag, "_misalign"}, 32'(misalign_W),      32'(exp_misalign()));
        check({tag, "_count"},    32'(retired_count),   m_count);
    endtask

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic step(input string tag);
        if (!rst) begin
            m_valid = 0; m_rw = 0; m_m2r = 0;
            m_type = 0; m_wreg = 0; m_alu = 0; m_rdata = 0; m_count = 0;
        end else begin
            if (m_valid && !stall) m_count = (m_count + 1) % (1 << CW);
            if (!stall) begin
                m_valid = valid_M; m_rw = RegWrite_M; m_m2r = MemToReg_M;
                m_type = LoadType_M; m_wreg = WriteRegister_M;
                m_alu = ALUResult_M; m_rdata = ReadData_M;
            end
            if (flush) m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit v, input bit rw, input bit m2r, input logic [2:0] lt,
                         input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] rd);
        valid_M = v; RegWrite_M = rw; MemToReg_M = m2r; LoadType_M = lt;
        WriteRegister_M = wr; ALUResult_M = alu; ReadData_M = rd;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1, 1, 1, 3'd1, 5'd9, 32'h3, 32'hFFFF_FFFF);
        step("rst0");
        step("rst1");
        check("rst_wdata_zero", WriteData_W, 32'h0);
        rst = 1'b1;

        drive(1, 1, 0, 3'd0, 5'd5, 32'h0000_00AB, 32'h0);
        step("alu");
        check("alu_wdata", WriteData_W, 32'h0000_00AB);
        check("alu_regwr", 32'(RegWrite_W), 32'd1);

        drive(1, 1, 1, 3'd1, 5'd6, 32'h0000_1002, 32'h8192_A3F4);
        step("lb");
        check("lb_wdata", WriteData_W, 32'hFFFF_FFA3);
        drive(1, 1, 1, 3'd2, 5'd6, 32'h0000_1002, 32'h8192_A3F4);
        step("lbu");
        check("lbu_wdata", WriteData_W, 32'h0000_00A3);
        drive(1, 1, 1, 3'd3, 5'd6, 32'h0000_1000, 32'h8192_A3F4);
        step("lh");
        check("lh_wdata", WriteData_W, 32'hFFFF_8192);

        drive(1, 1, 0, 3'd0, 5'd0, 32'h55, 32'h0);
        step("r0");
        check("r0_regwr", 32'(RegWrite_W), 32'd0);
        drive(1, 1, 0, 3'd0, 5'd7, 32'h1234, 32'h0);
        step("r0_next");

        drive(1, 1, 0, 3'd0, 5'd9, 32'hDEAD, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step("stall");
        check("stall_wdata", WriteData_W, 32'h1234);
        flush = 1'b1;
        step("stall_flush");
        check("stall_flush_valid", 32'(valid_W), 32'd0);
        check("stall_flush_wdata", WriteData_W, 32'h1234);
        stall = 1'b0; flush = 1'b0;

        drive(1, 1, 1, 3'd0, 5'd3, 32'h0000_1002, 32'hCAFE_F00D);
        step("lw_mis");
        check("lw_mis_flag", 32'(misalign_W), 32'd1);
        check("lw_mis_wdata", WriteData_W, 32'hCAFE_F00D);
        rst = 1'b0; stall = 1'b1; flush = 1'b1;
        step("mid_rst");
        check("mid_rst_count", 32'(retired_count), 32'd0);
        rst = 1'b1; stall = 1'b0; flush = 1'b0;

        // 2^CW - 1 retirements then one more: the counter must wrap to zero.
        drive(1, 0, 0, 3'd0, 5'd1, 32'h1, 32'h0);
        for (int i = 0; i < (1 << CW); i++) step("wrap_run");
        check("wrap_full", 32'(retired_count), 32'((1 << CW) - 1));
        step("wrap");
        check("wrap_zero", 32'(retired_count), 32'd0);

        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 49) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 6) == 0);
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_writeback_cycle
`default_nettype wire
